my_tdm_demux02: RTL

MY_TDM_DEMUX02 -- requirements
Module: my_tdm_demux02

---
 rtl/my_tdm_demux02.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/my_tdm_demux02.sv
// my_tdm_demux02: serial TDM demultiplexer for four channels.
// A frame starts on the bit where frame_sync is high. It carries four words,
// channel 0 first, each WORD_W bits long and sent MSB first. After each
// completed word, the matching y<ch> output is loaded and y_valid strobes.
// Optional feature: when MY_TDM_DEMUX02_PARITY_EN is defined, each word is
// followed by one even-parity bit, and a wrong parity bit strobes parity_err.
//
// Handshake: din and frame_sync are sampled only on rising edges where
// din_valid is high, and every other edge holds all state. y_valid,
// frame_done, sync_err and parity_err are one-cycle strobes. They are
// registered, so they appear one clock after the bit that caused them.
module my_tdm_demux02 #(
  parameter int WORD_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              din,
  input  logic              din_valid,
  input  logic              frame_sync,
  output logic [WORD_W-1:0] y0,
  output logic [WORD_W-1:0] y1,
  output logic [WORD_W-1:0] y2,
  output logic [WORD_W-1:0] y3,
  output logic              y_valid,
  output logic [1:0]        y_ch,
  output logic              frame_done,
  output logic              sync_err,
  output logic              parity_err,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WORD_W - 1);

`ifdef MY_TDM_DEMUX02_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1, PAR = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DATA = 2'd1} state_t;
`endif

  state_t            state, state_n;
  logic [1:0]        ch_cnt, ch_n;
  logic [BCW-1:0]    bit_cnt, bit_n;
  logic [WORD_W-1:0] shreg, sh_n;
  logic [WORD_W-1:0] word_full;
  logic [WORD_W-1:0] ld_word;
  logic              ld, fd_n, serr_n;
`ifdef MY_TDM_DEMUX02_PARITY_EN
  logic              perr_n;
`endif

  assign word_full = {shreg[WORD_W-2:0], din};
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // Next-state, counter and shift-register logic; completion produces ld.
  always_comb begin
    state_n = state;
    ch_n    = ch_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    ld      = 1'b0;
    ld_word = '0;
    fd_n    = 1'b0;
    serr_n  = 1'b0;
`ifdef MY_TDM_DEMUX02_PARITY_EN
    perr_n  = 1'b0;
`endif
    if (din_valid) begin
      case (state)
        IDLE: begin
          if (frame_sync) begin
            state_n = DATA;
            ch_n    = 2'd0;
            bit_n   = BCW'(1);
            sh_n    = {{(WORD_W-1){1'b0}}, din};
          end
        end
        DATA: begin
`ifdef MY_TDM_DEMUX02_PARITY_EN
          // The last bit of channel 3 is the parity bit, so every sync seen here is a resync.
          if (frame_sync) begin
`else
          if (frame_sync && !(bit_cnt == LAST_BIT && ch_cnt == 2'd3)) begin
`endif
            serr_n  = 1'b1;
            state_n = DATA;
            ch_n    = 2'd0;
            bit_n   = BCW'(1);
            sh_n    = {{(WORD_W-1){1'b0}}, din};
          end else if (bit_cnt == LAST_BIT) begin
`ifdef MY_TDM_DEMUX02_PARITY_EN
            state_n = PAR;
            sh_n    = word_full;
            bit_n   = '0;
`else
            ld      = 1'b1;
            ld_word = word_full;
            bit_n   = '0;
            sh_n    = word_full;
            if (ch_cnt == 2'd3) begin
              fd_n = 1'b1;
              ch_n = 2'd0;
              if (frame_sync) begin
                // This bit ends channel 3 and also starts the next frame.
                state_n = DATA;
                bit_n   = BCW'(1);
                sh_n    = {{(WORD_W-1){1'b0}}, din};
              end else begin
                state_n = IDLE;
              end
            end else begin
              ch_n = ch_cnt + 2'd1;
            end
`endif
          end else begin
            sh_n  = word_full;
            bit_n = bit_cnt + BCW'(1);
          end
        end
`ifdef MY_TDM_DEMUX02_PARITY_EN
        PAR: begin
          if (frame_sync && ch_cnt != 2'd3) begin
            serr_n  = 1'b1;
            state_n = DATA;
            ch_n    = 2'd0;
            bit_n   = BCW'(1);
            sh_n    = {{(WORD_W-1){1'b0}}, din};
          end else begin
            ld      = 1'b1;
            ld_word = shreg;
            perr_n  = (din != ^shreg);
            bit_n   = '0;
            if (ch_cnt == 2'd3) begin
              fd_n = 1'b1;
              ch_n = 2'd0;
              if (frame_sync) begin
                state_n = DATA;
                bit_n   = BCW'(1);
                sh_n    = {{(WORD_W-1){1'b0}}, din};
              end else begin
                state_n = IDLE;
              end
            end else begin
              ch_n    = ch_cnt + 2'd1;
              state_n = DATA;
            end
          end
        end
`endif
        default: state_n = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Counters, shift register, channel outputs and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt     <= 2'd0;
      bit_cnt    <= '0;
      shreg      <= '0;
      y0         <= '0;
      y1         <= '0;
      y2         <= '0;
      y3         <= '0;
      y_ch       <= 2'd0;
      y_valid    <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      ch_cnt     <= ch_n;
      bit_cnt    <= bit_n;
      shreg      <= sh_n;
      y_valid    <= ld;
      frame_done <= fd_n;
      sync_err   <= serr_n;
      if (ld) begin
        y_ch <= ch_cnt;
        case (ch_cnt)
          2'd0:    y0 <= ld_word;
          2'd1:    y1 <= ld_word;
          2'd2:    y2 <= ld_word;
          default: y3 <= ld_word;
        endcase
      end
    end
  end

`ifdef MY_TDM_DEMUX02_PARITY_EN
  // Parity error strobe, registered with y_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= perr_n;
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule
